systolic_array_ctrl: RTL and testbench
======================================

Name: systolic_array_ctrl

Overview:
Sequencer for the N×N weight-stationary MAC systolic array.
- On start, loads weights by reading N weight rows and shifting them down the array with the broadcast weight enable.
- Then streams M feature vectors, generates per-row skewed valids, and tracks results draining out of the array.
- Sits between the weight/feature buffers and the array; results go on to the quantization and activation path.

Parameters:
N, 4, array dimension (rows = columns); legal range 2..16
CNT_W, 16, width of the vector counter and feature address

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to run one job; sampled only in IDLE
num_vectors  in  CNT_W  M, the number of feature vectors; sampled with start
busy  out  1  high from the cycle after start is accepted until the end of the DONE cycle
done  out  1  one-cycle pulse when the job completes
w_rd_en  out  1  weight buffer read strobe; read data is valid 1 cycle later
w_rd_addr  out  $clog2(N)  weight row address
wen  out  1  broadcast weight enable to the array
f_rd_en  out  1  feature buffer read strobe; read data is valid 1 cycle later
f_rd_addr  out  CNT_W  feature vector index
feed_valid  out  N  per-row skewed valid; bit r = f_rd_en delayed r+1 cycles
out_valid  out  1  result row for one vector is at the array's south edge
out_idx  out  CNT_W  vector index of the current out_valid
keep_weights  in  1  present only with WEIGHT_REUSE_EN

Behaviour:
- Reset: every output is 0; state is IDLE; counters are 0; the delay lines are cleared. Reset mid-job aborts immediately with no done pulse.
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE -> LOAD_W on start. start is ignored in every other state.
- LOAD_W lasts exactly N+1 cycles.
  - Cycles 0..N-1: w_rd_en=1, w_rd_addr = N-1 down to 0, so the bottom row is read first.
  - wen = w_rd_en delayed 1 cycle, giving N wen cycles.
  - Last cycle: wait only.
  - Exit to STREAM if M>0, otherwise to DONE.
- STREAM lasts M cycles: f_rd_en=1, f_rd_addr = 0..M-1. After the last vector, go to DRAIN.
- feed_valid[r] = f_rd_en delayed r+1 cycles, implemented as a shift register.
- out_valid = f_rd_en delayed exactly 2N cycles: 1 read + (N-1) skew + N column accumulation.
- out_idx increments on each out_valid, starting from 0.
- DRAIN: exit to DONE in the cycle after the last out_valid, when the delay line is empty.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- M at its maximum (2^CNT_W-1) must not wrap the address; f_rd_addr stops at M-1.
- wen is never high during STREAM or DRAIN.

Optional Feature:
WEIGHT_REUSE_EN
- Defined:
  - Add the keep_weights port and an internal weights_loaded flag.
  - weights_loaded is set at LOAD_W exit and cleared by rst.
  - If start && keep_weights && weights_loaded, IDLE goes straight to STREAM (or to DONE if M=0); no w_rd_en or wen is issued.
- Undefined: the port is absent and every job performs LOAD_W.

Decomposition:
- Package systolic_pkg:
  - state enum: IDLE, LOAD_W, STREAM, DRAIN, DONE.
  - default N.
  - LAT_OUT = 2*N.
  - function giving the address width, $clog2(N).
- One sub-module, valid_delay_line: a parameterised-depth 1-bit shift register with async reset and tap outputs. It is used for feed_valid and out_valid.

Test Plan:
- N=4, M=3, start sampled at cycle 0 -> w_rd_en cycles 1-4 with addr 3,2,1,0; wen cycles 2-5; f_rd_en cycles 6-8 with addr 0-2; feed_valid[0] at 7-9 and feed_valid[3] at 10-12; out_valid at 14-16 with out_idx 0-2; done at 17; busy high 1-17.
- M=0 -> LOAD_W completes, done at cycle 6, no f_rd_en and no out_valid.
- start pulsed during STREAM -> ignored; counts and done timing are identical to the first case.
- rst asserted at cycle 10 of the first case -> all outputs 0 at once; no done; a new start after reset runs the full sequence.
- WEIGHT_REUSE_EN, second job with keep_weights=1, M=2 -> no wen; f_rd_en at cycles 1-2; out_valid at 9-10; done at 11.
- Back-to-back jobs (start the cycle after done) -> second job accepted; out_idx restarts at 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared state encoding and sizing helpers for the systolic array sequencer.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_N = 4;

  // A 1-row array still needs a 1-bit address port.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Feature read latency (1) + row skew (N-1) + column accumulation (N).
  function automatic int lat_out(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Parameterised-depth 1-bit shift register; tap i is i_din delayed i+1 cycles.
module valid_delay_line #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_din,
  output logic [DEPTH-1:0] o_taps
);

  logic [DEPTH-1:0] r_sh;

  // NOTE: non-blocking assignment lets every stage sample its neighbour's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sh <= '0;
    else     r_sh <= {r_sh[DEPTH-2:0], i_din};
  end

  assign o_taps = r_sh;

endmodule

// File: rtl/systolic_array_ctrl.sv
// Weight-stationary systolic array sequencer: weight load, feature stream, drain.
// Optional WEIGHT_REUSE_EN adds keep_weights to skip reloading resident weights.
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CNT_W = 16,
  localparam int AW   = addr_w(N)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef WEIGHT_REUSE_EN
  input  logic             keep_weights,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  output logic             busy,
  output logic             done,
  output logic             w_rd_en,
  output logic [AW-1:0]    w_rd_addr,
  output logic             wen,
  output logic             f_rd_en,
  output logic [CNT_W-1:0] f_rd_addr,
  output logic [N-1:0]     feed_valid,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_idx
);

  localparam int LAT = lat_out(N);

  state_t           r_state;
  logic [CNT_W-1:0] r_m;
  logic             r_busy, r_done, r_w_rd_en, r_wen, r_f_rd_en;
  logic [AW-1:0]    r_w_rd_addr;
  logic [CNT_W-1:0] r_f_rd_addr;
  logic [CNT_W-1:0] r_out_idx;
  logic [LAT-1:0]   w_taps;
  logic             w_line_busy;
  logic             w_skip_load;

`ifdef WEIGHT_REUSE_EN
  logic r_weights_loaded;
  assign w_skip_load = keep_weights && r_weights_loaded;
`else
  assign w_skip_load = 1'b0;
`endif

  valid_delay_line #(.DEPTH(LAT)) u_valid_line (
    .clk    (clk),
    .rst    (rst),
    .i_din  (r_f_rd_en),
    .o_taps (w_taps)
  );

  // Anything short of the output tap still in flight means results are pending.
  assign w_line_busy = |w_taps[LAT-2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_m         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_rd_en   <= 1'b0;
      r_w_rd_addr <= '0;
      r_wen       <= 1'b0;
      r_f_rd_en   <= 1'b0;
      r_f_rd_addr <= '0;
      r_out_idx   <= '0;
`ifdef WEIGHT_REUSE_EN
      r_weights_loaded <= 1'b0;
`endif
    end else begin
      r_wen  <= r_w_rd_en;
      r_done <= 1'b0;
      if (w_taps[LAT-1]) r_out_idx <= r_out_idx + 1'b1;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy    <= 1'b1;
            r_m       <= num_vectors;
            r_out_idx <= '0;
            if (!w_skip_load) begin
              r_state     <= LOAD_W;
              r_w_rd_en   <= 1'b1;
              r_w_rd_addr <= AW'(N - 1);
            end else if (num_vectors != '0) begin
              r_state     <= STREAM;
              r_f_rd_en   <= 1'b1;
              r_f_rd_addr <= '0;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end

        LOAD_W: begin
          if (r_w_rd_en) begin
            if (r_w_rd_addr == '0) r_w_rd_en   <= 1'b0;
            else                   r_w_rd_addr <= r_w_rd_addr - 1'b1;
          end else begin
            // Wait cycle: the last weight row is being written by wen.
`ifdef WEIGHT_REUSE_EN
            r_weights_loaded <= 1'b1;
`endif
            if (r_m != '0) begin
              r_state     <= STREAM;
              r_f_rd_en   <= 1'b1;
              r_f_rd_addr <= '0;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end

        STREAM: begin
          // Compare against M-1 so a maximal M never wraps the address.
          if (r_f_rd_addr == r_m - 1'b1) begin
            r_f_rd_en <= 1'b0;
            r_state   <= DRAIN;
          end else begin
            r_f_rd_addr <= r_f_rd_addr + 1'b1;
          end
        end

        DRAIN: begin
          if (!w_line_busy) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end

        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign w_rd_en    = r_w_rd_en;
  assign w_rd_addr  = r_w_rd_addr;
  assign wen        = r_wen;
  assign f_rd_en    = r_f_rd_en;
  assign f_rd_addr  = r_f_rd_addr;
  assign feed_valid = w_taps[N-1:0];
  assign out_valid  = w_taps[LAT-1];
  assign out_idx    = r_out_idx;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed self-checking bench for systolic_array_ctrl (N=4, CNT_W=16).
// Each cycle of a job is compared against a hand-derived job timeline.
module tb_systolic_array_ctrl;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int AW = 2;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic          wen;
    logic          f_rd_en;
    logic [CW-1:0] f_rd_addr;
    logic [N-1:0]  feed_valid;
    logic          out_valid;
    logic [CW-1:0] out_idx;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_vectors;
  logic          busy, done, w_rd_en, wen, f_rd_en, out_valid;
  logic [AW-1:0] w_rd_addr;
  logic [CW-1:0] f_rd_addr, out_idx;
  logic [N-1:0]  feed_valid;
`ifdef WEIGHT_REUSE_EN
  logic          keep_weights;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_array_ctrl #(.N(N), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef WEIGHT_REUSE_EN
    .keep_weights (keep_weights),
`endif
    .start        (start),
    .num_vectors  (num_vectors),
    .busy         (busy),
    .done         (done),
    .w_rd_en      (w_rd_en),
    .w_rd_addr    (w_rd_addr),
    .wen          (wen),
    .f_rd_en      (f_rd_en),
    .f_rd_addr    (f_rd_addr),
    .feed_valid   (feed_valid),
    .out_valid    (out_valid),
    .out_idx      (out_idx)
  );

  // raw=1 keeps address/index fields even when their strobe is low.
  function automatic obs_t sample(input bit raw);
    obs_t o;
    o            = '0;
    o.busy       = busy;
    o.done       = done;
    o.w_rd_en    = w_rd_en;
    o.w_rd_addr  = (raw || w_rd_en) ? w_rd_addr : '0;
    o.wen        = wen;
    o.f_rd_en    = f_rd_en;
    o.f_rd_addr  = (raw || f_rd_en) ? f_rd_addr : '0;
    o.feed_valid = feed_valid;
    o.out_valid  = out_valid;
    o.out_idx    = (raw || out_valid) ? out_idx : '0;
    return o;
  endfunction

  function automatic int done_cycle(input int m, input bit reuse);
    int l;
    l = reuse ? 0 : N + 1;
    return (m > 0) ? l + m + 2 * N + 1 : l + 1;
  endfunction

  // Cycle c counts from 1 = first cycle after start was sampled.
  function automatic obs_t exp_at(input int c, input int m, input bit reuse);
    obs_t e;
    int   l, d, k, j;
    e = '0;
    l = reuse ? 0 : N + 1;
    d = done_cycle(m, reuse);
    e.busy = (c >= 1 && c <= d);
    e.done = (c == d);
    if (!reuse && c >= 1 && c <= N) begin
      e.w_rd_en   = 1'b1;
      e.w_rd_addr = AW'(N - c);
    end
    e.wen = !reuse && c >= 2 && c <= N + 1;
    if (c > l && c <= l + m) begin
      e.f_rd_en   = 1'b1;
      e.f_rd_addr = CW'(c - l - 1);
    end
    for (int r = 0; r < N; r++) begin
      j = c - r - 1;
      e.feed_valid[r] = (j > l && j <= l + m);
    end
    k = c - 2 * N;
    if (k > l && k <= l + m) begin
      e.out_valid = 1'b1;
      e.out_idx   = CW'(k - l - 1);
    end
    return e;
  endfunction

  task automatic check(input string tag, input int c, input obs_t got, input obs_t exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed=%h expected=%h", tag, c, got, exp);
    end
  endtask

  task automatic drive_start(input int m, input bit reuse);
    @(negedge clk);
    start       = 1'b1;
    num_vectors = CW'(m);
`ifdef WEIGHT_REUSE_EN
    keep_weights = reuse;
`else
    if (reuse) $error("FAIL reuse_cfg: reuse requested without WEIGHT_REUSE_EN");
`endif
  endtask

  // inj > 0 raises start (with a bogus M) during cycle inj; it must be ignored.
  task automatic run_job(input string tag, input int m, input bit reuse, input int inj);
    int d;
    d = done_cycle(m, reuse);
    drive_start(m, reuse);
    for (int c = 1; c <= d; c++) begin
      @(negedge clk);
      start = (c == inj);
      if (c == inj) num_vectors = CW'(9);
      check(tag, c, sample(1'b0), exp_at(c, m, reuse));
    end
    start = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      check(tag, c, sample(1'b0), obs_t'('0));
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_vectors = '0;
`ifdef WEIGHT_REUSE_EN
    keep_weights = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 0, sample(1'b1), obs_t'('0));
    rst = 1'b0;
    idle("idle_after_reset", 2);

    // Reference job: M=3.
    run_job("m3", 3, 1'b0, 0);
    idle("m3_tail", 2);

    // Empty job: load only, done at cycle 6.
    run_job("m0", 0, 1'b0, 0);
    idle("m0_tail", 1);

    // Start pulsed mid-STREAM is ignored.
    run_job("start_in_stream", 3, 1'b0, 7);
    idle("inj_tail", 2);

    // Reset at cycle 10 of a reference job aborts with no done.
    drive_start(3, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      check("pre_abort", c, sample(1'b0), exp_at(c, 3, 1'b0));
    end
    rst = 1'b1;
    #1;
    check("abort_async", 10, sample(1'b1), obs_t'('0));
    @(negedge clk);
    rst = 1'b0;
    idle("abort_no_done", 4);
    run_job("after_reset", 3, 1'b0, 0);
    idle("after_reset_tail", 1);

    // Single vector, then back-to-back jobs with start in the cycle after done.
    run_job("m1", 1, 1'b0, 0);
    run_job("b2b_first", 2, 1'b0, 0);
    run_job("b2b_second", 3, 1'b0, 0);
    idle("b2b_tail", 2);

`ifdef WEIGHT_REUSE_EN
    run_job("reuse_m2", 2, 1'b1, 0);
    run_job("reuse_m0", 0, 1'b1, 0);
    idle("reuse_tail", 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
